dmem_copy_engine: RTL and testbench
===================================

# dmem_copy_engine

Bus-initiator block that moves words through the data-memory port (addr / datain / we / dataout), so that the data memory and its memory-mapped I/O registers can be filled or copied without CPU instructions. It sits beside the CPU in front of the data-memory port, behind an external arbiter that grants it the port. It operates in two modes: block copy (read source, then write destination) and block fill (write a constant). Because of the address-based I/O decode on that port, a destination with addr[7]=1 reaches the output port registers.

## Interface
- No parameters.
- clock  in  1  system clock; all state updates on rising edge
- clrn  in  1  asynchronous, active-low reset
- start  in  1  request a transfer; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  32  source byte address; bits [1:0] ignored
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- len  in  8  transfer length in words, 0..255
- fill_data  in  32  word written in fill mode
- bus_gnt  in  1  port granted this cycle; driven from a register by the arbiter, stable for the whole cycle
- dataout  in  32  read data from the data-memory port
- bus_req  out  1  engine wants the port
- addr  out  32  word-aligned address to the port (bits [1:0] = 00)
- datain  out  32  write data to the port
- we  out  1  write enable to the port
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- count  out  8  words written in the current or last transfer

## Operation
- States: IDLE, RD, WR, DONE.
- **IDLE**
  - bus_req=0, we=0, busy=0.
  - When start=1 at an edge, latch the following (pointer bits [1:0] forced to 0) and clear count to 0:
    - src_ptr, dst_ptr
    - rem = len
    - mode
    - fill_data
  - Next state: if len==0, go to DONE; else go to RD (copy) or WR (fill).
- **RD** (copy only)
  - bus_req=1, addr=src_ptr, we=0.
  - At an edge with bus_gnt=1: buf <= dataout, go to WR.
  - With bus_gnt=0: hold.
- **WR**
  - bus_req=1, addr=dst_ptr.
  - datain = buf (copy) or latched fill_data (fill).
  - we = bus_gnt, combinational; it is 0 whenever the grant is absent.
  - At an edge with bus_gnt=1:
    - count += 1, rem -= 1
    - dst_ptr += 4; src_ptr += 4 in copy mode
    - if rem was 1, go to DONE; else go to RD (copy) or stay in WR (fill).
  - With bus_gnt=0: hold all state.
- **DONE**
  - done=1, busy=0, bus_req=0, we=0.
  - Unconditionally go to IDLE.
- busy=1 exactly in RD and WR.
- start is ignored outside IDLE. The latched parameters are immune to input changes after acceptance.
- Pointers wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000). count never exceeds 255.
- In IDLE and DONE:
  - addr holds the last driven value (0 after reset).
  - datain holds its last value; we=0.
- Source/destination overlap is not checked. Words are moved strictly in ascending address order.

## Timing
- Reset (clrn=0, asynchronous): state=IDLE, every output 0 (bus_req, addr, datain, we, busy, done, count), and all internal registers 0.
  - Reset mid-transfer aborts immediately. No done pulse is produced.
  - A write whose cycle is cut by reset may or may not land.
- The memory's dataout is valid before the rising edge that ends an RD cycle; the engine captures it at that edge.
- we is 0 in the cycle in which reset releases.
- Throughput with continuous grant:
  - copy: 2 cycles per word
  - fill: 1 cycle per word
- Latency with continuous grant, counted from the start-accepting edge to the done cycle:
  - copy: 2·len + 1 cycles
  - fill: len + 1 cycles
  - len=0: done in the cycle immediately after acceptance
- done is asserted in the cycle after the final write edge. count is already final in that cycle and holds until the next accepted start.
- A start is accepted at the earliest edge in which the state is IDLE, i.e. 2 cycles after the done-cycle start at the earliest.

## Test plan
- Reset values: with clrn low, and again after its release, all outputs read 0.
- Copy:
  - Stimulus: preload words 0x11,0x22,0x33 at byte addresses 0x00,0x04,0x08; start copy src=0x00, dst=0x40, len=3, bus_gnt held 1.
  - Expected: memory 0x40..0x48 = 0x11,0x22,0x33; done pulses exactly 7 cycles after the accepting edge; count=3; we asserted 3 times.
- Fill to the I/O region:
  - Stimulus: mode=1, dst=0x80, len=1, fill_data=0xA5A5A5A5.
  - Expected: out_port0 = 0xA5A5A5A5; done pulses 2 cycles after the accepting edge.
- Grant stall:
  - Stimulus: copy with len=2, with bus_gnt deasserted for 3 cycles during the first RD and for 2 cycles during the second WR.
  - Expected: we=0 throughout the stalls; addr stable during them; correct data written; done delayed by exactly 5 cycles.
- Boundaries:
  - len=0 → done the next cycle, count=0, no write.
  - dst=0xFFFFFFFC, len=2 (fill) → writes at 0xFFFFFFFC, then 0x00000000.
  - src_addr=0x03 → addr=0x00.
- Abort and re-start:
  - Pull clrn low mid-copy (after 1 word) → outputs 0 at once, no done pulse.
  - Pulse start while busy → the pulse is ignored and the transfer is unaffected.

Source files
------------

// File: rtl/dmem_copy_engine.sv
// Block copy / fill initiator on the data-memory port.
// Copy moves one word per RD+WR pair; fill writes a latched constant every granted cycle.
module dmem_copy_engine (
   input  logic        clock,
   input  logic        clrn,
   input  logic        start,
   input  logic        mode,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [7:0]  len,
   input  logic [31:0] fill_data,
   input  logic        bus_gnt,
   input  logic [31:0] dataout,
   output logic        bus_req,
   output logic [31:0] addr,
   output logic [31:0] datain,
   output logic        we,
   output logic        busy,
   output logic        done,
   output logic [7:0]  count
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

   state_e      r_state;
   logic [31:0] r_src;
   logic [31:0] r_dst;
   logic [31:0] r_fill;
   logic [31:0] r_buf;
   logic [31:0] r_addr_hold;
   logic [31:0] r_data_hold;
   logic [7:0]  r_rem;
   logic [7:0]  r_count;
   logic        r_mode;
   logic [31:0] w_wr_data;

   assign w_wr_data = r_mode ? r_fill : r_buf;

   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         r_state     <= StIdle;
         r_src       <= '0;
         r_dst       <= '0;
         r_fill      <= '0;
         r_buf       <= '0;
         r_addr_hold <= '0;
         r_data_hold <= '0;
         r_rem       <= '0;
         r_count     <= '0;
         r_mode      <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_src   <= src_addr & 32'hFFFF_FFFC;
                  r_dst   <= dst_addr & 32'hFFFF_FFFC;
                  r_rem   <= len;
                  r_mode  <= mode;
                  r_fill  <= fill_data;
                  r_count <= '0;
                  if (len == 8'd0)  r_state <= StDone;
                  else if (mode)    r_state <= StWr;
                  else              r_state <= StRd;
               end
            end
            StRd: begin
               r_addr_hold <= r_src;
               if (bus_gnt) begin
                  r_buf   <= dataout;
                  r_state <= StWr;
               end
            end
            StWr: begin
               // Remember what was driven so addr/datain hold once the engine goes quiet.
               r_addr_hold <= r_dst;
               r_data_hold <= w_wr_data;
               if (bus_gnt) begin
                  r_count <= r_count + 8'd1;
                  r_rem   <= r_rem - 8'd1;
                  r_dst   <= r_dst + 32'd4;
                  if (!r_mode) r_src <= r_src + 32'd4;
                  if (r_rem == 8'd1) r_state <= StDone;
                  else if (r_mode)   r_state <= StWr;
                  else               r_state <= StRd;
               end
            end
            StDone:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy    = (r_state == StRd) || (r_state == StWr);
   assign bus_req = busy;
   assign done    = (r_state == StDone);
   assign we      = (r_state == StWr) && bus_gnt;
   assign count   = r_count;

   always_comb begin
      addr   = r_addr_hold;
      datain = r_data_hold;
      case (r_state)
         StRd:    addr = r_src;
         StWr: begin
            addr   = r_dst;
            datain = w_wr_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: memory + I/O port model, write log and
// a transfer-level reference model of the expected write sequence.
module tb_dmem_copy_engine;

   logic        clock = 1'b0;
   logic        clrn = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [7:0]  len = '0;
   logic [31:0] fill_data = '0;
   logic        bus_gnt = 1'b0;
   logic [31:0] dataout;
   logic        bus_req;
   logic [31:0] addr;
   logic [31:0] datain;
   logic        we;
   logic        busy;
   logic        done;
   logic [7:0]  count;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] out_port0;
   logic [31:0] log_addr [0:1023];
   logic [31:0] log_data [0:1023];
   int          wr_n = 0;
   int          done_n = 0;
   logic        pre_we = 1'b0;
   logic [31:0] pre_addr = '0;
   logic [31:0] pre_data = '0;

   dmem_copy_engine dut (
      .clock     (clock),
      .clrn      (clrn),
      .start     (start),
      .mode      (mode),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .fill_data (fill_data),
      .bus_gnt   (bus_gnt),
      .dataout   (dataout),
      .bus_req   (bus_req),
      .addr      (addr),
      .datain    (datain),
      .we        (we),
      .busy      (busy),
      .done      (done),
      .count     (count)
   );

   always #5 clock = ~clock;

   assign dataout = mem[addr[9:2]];

   // Data memory with addr[7] decoded to the output port register.
   always @(posedge clock) begin
      if (pre_we) mem[pre_addr[9:2]] <= pre_data;
      if (we) begin
         log_addr[wr_n] <= addr;
         log_data[wr_n] <= datain;
         wr_n <= wr_n + 1;
         if (addr[7]) out_port0 <= datain;
         else         mem[addr[9:2]] <= datain;
      end
      if (done) done_n <= done_n + 1;
   end

   function automatic logic [31:0] exp_addr(input logic [31:0] d, input int i);
      return (d & 32'hFFFF_FFFC) + 32'(4 * i);
   endfunction

   function automatic logic [31:0] exp_data(input logic m, input logic [31:0] s,
                                            input logic [31:0] f, input int i);
      logic [31:0] a;
      a = (s & 32'hFFFF_FFFC) + 32'(4 * i);
      return m ? f : ref_mem[a[9:2]];
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      @(posedge clock); #1;
      pre_we = 1'b1;
      pre_addr = a;
      pre_data = v;
      ref_mem[a[9:2]] = v;
      @(posedge clock); #1;
      pre_we = 1'b0;
   endtask

   // Start one transfer and follow it to its done pulse; checks stall behaviour on the way.
   task automatic run_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [7:0] l, input logic [31:0] f, input logic [63:0] gmask,
                           input bit rnd_gnt, input int poke, output int cycles, output int base,
                           output logic [31:0] first_addr, output logic [7:0] cnt_done);
      bit          got;
      bit          prev_stall;
      logic [31:0] prev_addr;
      got = 0;
      prev_stall = 0;
      prev_addr = '0;
      cycles = 0;
      first_addr = '0;
      cnt_done = '0;
      repeat (2) @(posedge clock);
      #1;
      mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f; start = 1'b1;
      base = wr_n;
      @(posedge clock); #1;
      for (int n = 1; n <= 2000; n++) begin
         bus_gnt = rnd_gnt ? 1'($urandom_range(0, 1)) : (n < 64 ? gmask[n] : 1'b1);
         if (n == poke) begin
            start = 1'b1; mode = ~m; len = 8'd0; dst_addr = 32'h300; fill_data = ~f;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         if (n == 1) first_addr = addr;
         if (busy && !bus_gnt) begin
            checks++;
            if (we !== 1'b0) begin
               failures++;
               $display("FAIL stall_we cycle %0d: got %b want 0", n, we);
            end
         end
         if (prev_stall && busy) begin
            checks++;
            if (addr !== prev_addr) begin
               failures++;
               $display("FAIL stall_addr cycle %0d: got %h want %h", n, addr, prev_addr);
            end
         end
         prev_stall = busy && !bus_gnt;
         prev_addr = addr;
         if (done) begin
            cycles = n;
            cnt_done = count;
            got = 1;
            break;
         end
         @(posedge clock); #1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL xfer_timeout: got no done want done within 2000 cycles");
      end else begin
         @(posedge clock); #1;
         bus_gnt = 1'b0;
         start = 1'b0;
         @(negedge clock);
         checks++;
         if (done !== 1'b0 || count !== cnt_done) begin
            failures++;
            $display("FAIL done_pulse_hold: got done=%b count=%0d want done=0 count=%0d",
                     done, count, cnt_done);
         end
      end
      start = 1'b0;
      bus_gnt = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({bus_req, addr, datain, we, busy, done, count} !== '0) begin
         failures++;
         $display("FAIL reset_low: got %h want 0", {bus_req, addr, datain, we, busy, done, count});
      end
      @(posedge clock); #1;
      clrn = 1'b1;
      @(negedge clock);
      checks++;
      if ({bus_req, addr, datain, we, busy, done, count} !== '0) begin
         failures++;
         $display("FAIL reset_release: got %h want 0",
                  {bus_req, addr, datain, we, busy, done, count});
      end
   endtask

   task automatic test_copy;
      int cy, b;
      logic [31:0] fa;
      logic [7:0] cd;
      preload(32'h00, 32'h11);
      preload(32'h04, 32'h22);
      preload(32'h08, 32'h33);
      run_xfer(1'b0, 32'h00, 32'h40, 8'd3, 32'h0, '1, 0, 0, cy, b, fa, cd);
      checks++;
      if (cy != 7 || cd !== 8'd3 || wr_n - b != 3) begin
         failures++;
         $display("FAIL copy_timing: got cycles=%0d count=%0d writes=%0d want 7 3 3",
                  cy, cd, wr_n - b);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem[16 + i] !== 32'(8'h11 * (i + 1))) begin
            failures++;
            $display("FAIL copy_mem[%0d]: got %h want %h", i, mem[16 + i], 32'(8'h11 * (i + 1)));
         end
      end
   endtask

   task automatic test_fill_io;
      int cy, b;
      logic [31:0] fa;
      logic [7:0] cd;
      run_xfer(1'b1, 32'h0, 32'h80, 8'd1, 32'hA5A5A5A5, '1, 0, 0, cy, b, fa, cd);
      checks++;
      if (cy != 2 || out_port0 !== 32'hA5A5A5A5 || wr_n - b != 1) begin
         failures++;
         $display("FAIL fill_io: got cycles=%0d port=%h writes=%0d want 2 a5a5a5a5 1",
                  cy, out_port0, wr_n - b);
      end
   endtask

   task automatic test_grant_stall;
      int cy, b;
      logic [31:0] fa;
      logic [7:0] cd;
      logic [63:0] gm;
      gm = '1;
      gm[1] = 1'b0; gm[2] = 1'b0; gm[3] = 1'b0; gm[7] = 1'b0; gm[8] = 1'b0;
      preload(32'h20, $urandom);
      preload(32'h24, $urandom);
      run_xfer(1'b0, 32'h20, 32'h60, 8'd2, 32'h0, gm, 0, 0, cy, b, fa, cd);
      checks++;
      if (cy != 10 || wr_n - b != 2) begin
         failures++;
         $display("FAIL stall_timing: got cycles=%0d writes=%0d want 10 2", cy, wr_n - b);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (log_addr[b + i] !== exp_addr(32'h60, i)
             || log_data[b + i] !== exp_data(1'b0, 32'h20, 32'h0, i)) begin
            failures++;
            $display("FAIL stall_write[%0d]: got %h/%h want %h/%h", i, log_addr[b + i],
                     log_data[b + i], exp_addr(32'h60, i), exp_data(1'b0, 32'h20, 32'h0, i));
         end
      end
   endtask

   task automatic test_boundaries;
      int cy, b;
      logic [31:0] fa;
      logic [7:0] cd;
      run_xfer(1'b0, 32'h0, 32'h100, 8'd0, 32'h0, '1, 0, 0, cy, b, fa, cd);
      checks++;
      if (cy != 1 || cd !== 8'd0 || wr_n != b) begin
         failures++;
         $display("FAIL len_zero: got cycles=%0d count=%0d writes=%0d want 1 0 0",
                  cy, cd, wr_n - b);
      end
      run_xfer(1'b1, 32'h0, 32'hFFFF_FFFC, 8'd2, 32'h5A5A0F0F, '1, 0, 0, cy, b, fa, cd);
      checks++;
      if (wr_n - b != 2 || log_addr[b] !== 32'hFFFF_FFFC || log_addr[b + 1] !== 32'h0
          || cy != 3) begin
         failures++;
         $display("FAIL wrap: got writes=%0d a0=%h a1=%h cycles=%0d want 2 fffffffc 0 3",
                  wr_n - b, log_addr[b], log_addr[b + 1], cy);
      end
      preload(32'h00, $urandom);
      run_xfer(1'b0, 32'h03, 32'h44, 8'd1, 32'h0, '1, 0, 0, cy, b, fa, cd);
      checks++;
      if (fa !== 32'h0 || log_data[b] !== ref_mem[0] || log_addr[b] !== 32'h44) begin
         failures++;
         $display("FAIL src_align: got addr=%h data=%h dst=%h want 0 %h 44",
                  fa, log_data[b], log_addr[b], ref_mem[0]);
      end
   endtask

   task automatic test_start_while_busy;
      int cy, b;
      logic [31:0] fa, f;
      logic [7:0] cd;
      f = $urandom;
      run_xfer(1'b1, 32'h0, 32'h100, 8'd4, f, '1, 0, 2, cy, b, fa, cd);
      checks++;
      if (cy != 5 || cd !== 8'd4 || wr_n - b != 4) begin
         failures++;
         $display("FAIL busy_start: got cycles=%0d count=%0d writes=%0d want 5 4 4",
                  cy, cd, wr_n - b);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (log_addr[b + i] !== exp_addr(32'h100, i) || log_data[b + i] !== f) begin
            failures++;
            $display("FAIL busy_start_write[%0d]: got %h/%h want %h/%h", i, log_addr[b + i],
                     log_data[b + i], exp_addr(32'h100, i), f);
         end
      end
   endtask

   task automatic test_abort;
      int dn;
      bit hit;
      hit = 0;
      @(posedge clock); #1;
      mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h140; len = 8'd3; start = 1'b1;
      bus_gnt = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (count == 8'd1) begin
            hit = 1;
            break;
         end
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL abort_progress: got count=%0d want 1", count);
      end
      #1 clrn = 1'b0;
      #1;
      dn = done_n;
      checks++;
      if ({bus_req, addr, datain, we, busy, done, count} !== '0) begin
         failures++;
         $display("FAIL abort_outputs: got %h want 0",
                  {bus_req, addr, datain, we, busy, done, count});
      end
      repeat (2) @(posedge clock);
      #1 clrn = 1'b1;
      @(negedge clock);
      checks++;
      if (we !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_release: got we=%b busy=%b want 0 0", we, busy);
      end
      repeat (8) @(negedge clock);
      checks++;
      if (done_n != dn || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_done: got done pulses=%0d busy=%b want 0 0", done_n - dn, busy);
      end
      bus_gnt = 1'b0;
   endtask

   task automatic test_random;
      int cy, b;
      logic [31:0] fa, s, d, f;
      logic [7:0] cd, l;
      logic m;
      for (int it = 0; it < 6; it++) begin
         m = 1'($urandom_range(0, 1));
         l = 8'($urandom_range(1, 32));
         s = 32'($urandom_range(0, 31) * 4) | 32'($urandom_range(0, 3));
         d = 32'($urandom_range(128, 191) * 4) | 32'($urandom_range(0, 3));
         f = $urandom;
         if (!m) begin
            for (int i = 0; i < int'(l); i++) preload(exp_addr(s, i), $urandom);
         end
         run_xfer(m, s, d, l, f, '1, 1, 0, cy, b, fa, cd);
         checks++;
         if (cd !== l || wr_n - b != int'(l)) begin
            failures++;
            $display("FAIL rand%0d_count: got count=%0d writes=%0d want %0d", it, cd, wr_n - b, l);
         end
         for (int i = 0; i < int'(l); i++) begin
            checks++;
            if (log_addr[b + i] !== exp_addr(d, i) || log_data[b + i] !== exp_data(m, s, f, i)) begin
               failures++;
               $display("FAIL rand%0d_write[%0d]: got %h/%h want %h/%h", it, i, log_addr[b + i],
                        log_data[b + i], exp_addr(d, i), exp_data(m, s, f, i));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_copy();
      test_fill_io();
      test_grant_stall();
      test_boundaries();
      test_start_while_busy();
      test_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
